// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared scheduler constants and clog2 helper
package sched_pkg;

  localparam int ARB_FIXED       = 0;
  localparam int ARB_RR          = 1;
  localparam int SCHED_AER_WIDTH = 12;
  localparam int SCHED_DEPTH     = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sched_chan_fifo.sv
// rtl/sched_chan_fifo.sv - one circular event FIFO with occupancy, flush and show-ahead head
module sched_chan_fifo #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 128,
  parameter int DEPTH_ADDR = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_ADDR:0]   occ,
  output logic [WIDTH-1:0]      head_data
);

  localparam logic [DEPTH_ADDR:0]   OCC_FULL = (DEPTH_ADDR + 1)'(DEPTH);
  localparam logic [DEPTH_ADDR:0]   OCC_ONE  = (DEPTH_ADDR + 1)'(1);
  localparam logic [DEPTH_ADDR-1:0] PTR_ONE  = DEPTH_ADDR'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_ADDR:0]   occ_q, occ_d;
  logic                  push_ok, pop_ok;

  assign full      = (occ_q == OCC_FULL);
  assign empty     = (occ_q == '0);
  assign occ       = occ_q;
  assign head_data = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a pop never frees room for a same-cycle push.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is never cleared; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sched_mc_arb.sv
// rtl/sched_mc_arb.sv - multi-channel AER scheduler: per-channel FIFOs arbitrated onto one output
// Optional drop counter output enabled by SCHED_DROP_CNT_EN.
module sched_mc_arb
  import sched_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int AER_WIDTH  = SCHED_AER_WIDTH,
  parameter int DEPTH      = SCHED_DEPTH,
  parameter int DEPTH_ADDR = clog2(DEPTH),
  parameter int ARB_MODE   = ARB_FIXED,
  parameter int CH_W       = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                               CLK,
  input  logic                               RSTN,
  input  logic [NUM_CH-1:0]                  CTRL_SCHED_EVENT_IN,
  input  logic [NUM_CH*AER_WIDTH-1:0]        CTRL_SCHED_DATA_IN,
  input  logic                               CTRL_SCHED_POP_N,
  input  logic                               CTRL_SCHED_FLUSH,
  output logic                               SCHED_EMPTY,
  output logic [NUM_CH-1:0]                  SCHED_FULL,
  output logic [AER_WIDTH-1:0]               SCHED_DATA_OUT,
  output logic [CH_W-1:0]                    SCHED_CH_OUT,
  output logic [NUM_CH*(DEPTH_ADDR+1)-1:0]   SCHED_OCC
`ifdef SCHED_DROP_CNT_EN
  , output logic [15:0]                      SCHED_DROP_CNT
`endif
);

  logic [NUM_CH-1:0]    chan_empty;
  logic [NUM_CH-1:0]    chan_full;
  logic [NUM_CH-1:0]    chan_pop;
  logic [AER_WIDTH-1:0] chan_head [NUM_CH];
  logic [DEPTH_ADDR:0]  chan_occ  [NUM_CH];

  logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]      search_base;
  logic [CH_W-1:0]      cand;
  logic [CH_W-1:0]      grant_idx;
  logic                 grant_valid;
  logic                 pop_eff;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    sched_chan_fifo #(
      .WIDTH      (AER_WIDTH),
      .DEPTH      (DEPTH),
      .DEPTH_ADDR (DEPTH_ADDR)
    ) u_fifo (
      .clk       (CLK),
      .rst_n     (RSTN),
      .push      (CTRL_SCHED_EVENT_IN[i]),
      .push_data (CTRL_SCHED_DATA_IN[i*AER_WIDTH +: AER_WIDTH]),
      .pop       (chan_pop[i]),
      .flush     (CTRL_SCHED_FLUSH),
      .full      (chan_full[i]),
      .empty     (chan_empty[i]),
      .occ       (chan_occ[i]),
      .head_data (chan_head[i])
    );

    assign chan_pop[i] = pop_eff && (grant_idx == CH_W'(i));
    assign SCHED_OCC[i*(DEPTH_ADDR+1) +: (DEPTH_ADDR+1)] = chan_occ[i];
  end

  // Fixed priority is round-robin search pinned to base 0.
  always_comb begin
    search_base = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(search_base) + k) % NUM_CH);
      if (!grant_valid && !chan_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign pop_eff        = !CTRL_SCHED_POP_N && grant_valid;
  assign SCHED_EMPTY    = &chan_empty;
  assign SCHED_FULL     = chan_full;
  assign SCHED_DATA_OUT = grant_valid ? chan_head[grant_idx] : '0;
  assign SCHED_CH_OUT   = grant_idx;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (CTRL_SCHED_FLUSH) begin
      rr_ptr_d = '0;
    end else if (pop_eff && (ARB_MODE == ARB_RR)) begin
      rr_ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

`ifdef SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int k = 0; k < NUM_CH; k++) begin
      if (CTRL_SCHED_EVENT_IN[k] && chan_full[k]) drop_sum = drop_sum + 17'd1;
    end
    if (CTRL_SCHED_FLUSH)          drop_cnt_d = '0;
    else if (drop_sum > 17'h0FFFF) drop_cnt_d = 16'hFFFF;
    else                           drop_cnt_d = drop_sum[15:0];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign SCHED_DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sched_mc_arb.sv
// tb/tb_sched_mc_arb.sv - directed self-checking bench for sched_mc_arb (fixed and round-robin instances)
module tb_sched_mc_arb;

  logic        CLK;
  logic        RSTN;
  logic [1:0]  ev_in;
  logic [23:0] data_in;
  logic        pop_n;
  logic        flush;

  logic        empty_f, empty_r;
  logic [1:0]  full_f, full_r;
  logic [11:0] dout_f, dout_r;
  logic        ch_f, ch_r;
  logic [15:0] occ_f, occ_r;
`ifdef SCHED_DROP_CNT_EN
  logic [15:0] drop_f, drop_r;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sched_mc_arb #(.ARB_MODE(0)) u_fix (
    .CLK                 (CLK),
    .RSTN                (RSTN),
    .CTRL_SCHED_EVENT_IN (ev_in),
    .CTRL_SCHED_DATA_IN  (data_in),
    .CTRL_SCHED_POP_N    (pop_n),
    .CTRL_SCHED_FLUSH    (flush),
    .SCHED_EMPTY         (empty_f),
    .SCHED_FULL          (full_f),
    .SCHED_DATA_OUT      (dout_f),
    .SCHED_CH_OUT        (ch_f),
    .SCHED_OCC           (occ_f)
`ifdef SCHED_DROP_CNT_EN
    , .SCHED_DROP_CNT    (drop_f)
`endif
  );

  sched_mc_arb #(.ARB_MODE(1)) u_rr (
    .CLK                 (CLK),
    .RSTN                (RSTN),
    .CTRL_SCHED_EVENT_IN (ev_in),
    .CTRL_SCHED_DATA_IN  (data_in),
    .CTRL_SCHED_POP_N    (pop_n),
    .CTRL_SCHED_FLUSH    (flush),
    .SCHED_EMPTY         (empty_r),
    .SCHED_FULL          (full_r),
    .SCHED_DATA_OUT      (dout_r),
    .SCHED_CH_OUT        (ch_r),
    .SCHED_OCC           (occ_r)
`ifdef SCHED_DROP_CNT_EN
    , .SCHED_DROP_CNT    (drop_r)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [11:0] exp_rr  [4];
  logic [11:0] exp_fix [4];

  initial begin
    RSTN = 1'b0; ev_in = '0; data_in = '0; pop_n = 1'b1; flush = 1'b0;
    exp_rr  = '{12'h001, 12'h101, 12'h002, 12'h102};
    exp_fix = '{12'h001, 12'h002, 12'h101, 12'h102};
    step(); step();
    RSTN = 1'b1;
    step();
    check("rst_empty", 32'(empty_f), 32'd1);
    check("rst_full", 32'(full_f), 32'd0);
    check("rst_data", 32'(dout_f), 32'd0);
    check("rst_ch", 32'(ch_f), 32'd0);
    check("rst_occ", 32'(occ_f), 32'd0);
    check("rst_rr_empty", 32'(empty_r), 32'd1);

    // fixed priority: ch1 first, then ch0; ch0 still wins
    ev_in = 2'b10; data_in = {12'h011, 12'h000}; step();
    ev_in = 2'b01; data_in = {12'h000, 12'h022}; step();
    ev_in = 2'b00;
    check("fix_data0", 32'(dout_f), 32'h022);
    check("fix_ch0", 32'(ch_f), 32'd0);
    check("fix_occ", 32'(occ_f), 32'h0101);
    pop_n = 1'b0; step(); pop_n = 1'b1;
    check("fix_data1", 32'(dout_f), 32'h011);
    check("fix_ch1", 32'(ch_f), 32'd1);
    pop_n = 1'b0; step(); pop_n = 1'b1;
    check("fix_empty", 32'(empty_f), 32'd1);
    check("fix_empty_data", 32'(dout_f), 32'd0);

    flush = 1'b1; step(); flush = 1'b0;

    // round robin vs fixed ordering on the same load
    ev_in = 2'b11; data_in = {12'h101, 12'h001}; step();
    data_in = {12'h102, 12'h002}; step();
    ev_in = 2'b00;
    pop_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_pop%0d", k), 32'(dout_r), 32'(exp_rr[k]));
      check($sformatf("fixord_pop%0d", k), 32'(dout_f), 32'(exp_fix[k]));
      step();
    end
    pop_n = 1'b1;
    check("rr_empty", 32'(empty_r), 32'd1);
    check("fixord_empty", 32'(empty_f), 32'd1);

    // fill ch0 across the physical wrap (pointers start at 2)
    for (int i = 0; i < 128; i++) begin
      ev_in = 2'b01; data_in = {12'h000, 12'(i)}; step();
    end
    ev_in = 2'b00;
    check("fill_full", 32'(full_f), 32'b01);
    check("fill_occ", 32'(occ_f), 32'h0080);
    ev_in = 2'b01; data_in = {12'h000, 12'hFFF}; step(); ev_in = 2'b00;
    check("drop_occ", 32'(occ_f), 32'h0080);
`ifdef SCHED_DROP_CNT_EN
    check("drop_cnt1", 32'(drop_f), 32'd1);
`endif
    ev_in = 2'b01; data_in = {12'h000, 12'hEEE}; pop_n = 1'b0; step();
    ev_in = 2'b00; pop_n = 1'b1;
    check("fullpp_occ", 32'(occ_f), 32'h007F);
    check("fullpp_full", 32'(full_f), 32'b00);
`ifdef SCHED_DROP_CNT_EN
    check("drop_cnt2", 32'(drop_f), 32'd2);
`endif
    pop_n = 1'b0;
    for (int i = 1; i < 128; i++) begin
      check($sformatf("wrap_pop%0d", i), 32'(dout_f), 32'(i));
      step();
    end
    pop_n = 1'b1;
    check("wrap_empty", 32'(empty_f), 32'd1);
    check("wrap_occ", 32'(occ_f), 32'd0);

    // flush overrides concurrent push and pop
    for (int i = 0; i < 5; i++) begin
      ev_in = 2'b01; data_in = {12'h000, 12'(12'h050 + i)}; step();
    end
    check("preflush_occ", 32'(occ_f), 32'h0005);
    flush = 1'b1; ev_in = 2'b11; pop_n = 1'b0; data_in = {12'h077, 12'h066}; step();
    flush = 1'b0; ev_in = 2'b00; pop_n = 1'b1;
    check("flush_empty", 32'(empty_f), 32'd1);
    check("flush_occ", 32'(occ_f), 32'd0);
    check("flush_rr_occ", 32'(occ_r), 32'd0);
`ifdef SCHED_DROP_CNT_EN
    check("flush_drop", 32'(drop_f), 32'd0);
`endif
    step();
    check("postflush_empty", 32'(empty_f), 32'd1);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      ev_in = 2'b10; data_in = {12'(12'h031 + i), 12'h000}; step();
    end
    ev_in = 2'b00;
    check("prerst_data", 32'(dout_f), 32'h031);
    check("prerst_ch", 32'(ch_f), 32'd1);
    check("prerst_occ", 32'(occ_f), 32'h0300);
    #2 RSTN = 1'b0;
    #1;
    check("arst_empty", 32'(empty_f), 32'd1);
    check("arst_data", 32'(dout_f), 32'd0);
    check("arst_ch", 32'(ch_f), 32'd0);
    check("arst_occ", 32'(occ_f), 32'd0);
    check("arst_full", 32'(full_f), 32'd0);
    step(); step();
    RSTN = 1'b1;
    step();
    ev_in = 2'b01; data_in = {12'h000, 12'h0AB}; step(); ev_in = 2'b00;
    check("post_data", 32'(dout_f), 32'h0AB);
    check("post_ch", 32'(ch_f), 32'd0);
    check("post_occ", 32'(occ_f), 32'h0001);
    data_in = {12'h000, 12'h555};
    #1;
    check("no_comb_path", 32'(dout_f), 32'h0AB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
